int_wb_arbiter: RTL and testbench
=================================

INT_WB_ARBITER -- requirements
Module: int_wb_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-003 Parameter IDX_W, default 5, SHALL set the architectural register index width.
REQ-004 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive-loss cycles before the multi-cycle (MC) result is forced; legal range 1..15.
REQ-005 Port list, one entry per port:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_pipe_valid  in  1  in-order commit write request.
- i_pipe_idx  in  IDX_W  commit destination.
- i_pipe_data  in  DATA_W  commit data.
- o_pipe_stall  out  1  commit stage must hold this cycle (combinational).
- i_mc_valid  in  1  MC unit result valid.
- i_mc_idx  in  IDX_W  MC destination.
- i_mc_data  in  DATA_W  MC data.
- o_mc_ready  out  1  holding buffer can accept (registered).
- i_flush  in  1  pipeline flush.
- o_wb_valid  out  1  regfile write enable (registered).
- o_wb_idx  out  IDX_W  write index.
- o_wb_data  out  DATA_W  write data.
- o_mc_pending  out  1  buffer occupied (registered).

Function
REQ-006 The MC transfer SHALL complete on a cycle where i_mc_valid & o_mc_ready; the result is then captured into a one-entry holding buffer.
REQ-007 o_mc_ready SHALL equal ~buffer-occupied; the MC side SHALL NOT be accepted and drained in the same cycle.
REQ-008 The state machine SHALL have three states:
- EMPTY: no buffer.
- HELD: buffer occupied, pipe has priority.
- FORCE: buffer occupied, starvation reached.
REQ-009 EMPTY SHALL go to HELD on MC accept.
REQ-010 In HELD with i_pipe_valid & ~i_flush, the pipe SHALL be granted and the starve counter SHALL increment.
REQ-011 In HELD with no effective pipe request, the buffer SHALL be granted and the state SHALL return to EMPTY.
REQ-012 HELD SHALL go to FORCE when the counter reaches STARVE_LIMIT.
REQ-013 In FORCE, the buffer SHALL be granted unconditionally, o_pipe_stall SHALL be 1 that cycle, and the state SHALL go to EMPTY.
REQ-014 The starve counter SHALL be 4 bits, clear on every buffer grant and in EMPTY, and never wrap.
REQ-015 The effective pipe request SHALL be i_pipe_valid & ~i_flush & ~stall; a flushed pipe request SHALL produce no write.
REQ-016 The granted write SHALL appear on o_wb_* exactly one cycle after the grant.
REQ-017 o_wb_valid SHALL be 0 for a granted idx of 0; that grant still consumes the slot and frees the buffer.
REQ-018 o_wb_idx and o_wb_data SHALL be 0 whenever o_wb_valid is 0.
REQ-019 o_pipe_stall SHALL be 0 outside FORCE.
REQ-020 In EMPTY an incoming MC result SHALL never bypass to o_wb_* in the accept cycle.
REQ-021 On i_flush with the buffer occupied, the buffered result SHALL survive, unless WB_ARB_FLUSH_KILL_MC_EN is defined.

Reset
REQ-022 While i_rst is high at a clock edge, the block SHALL set:
- state to EMPTY, buffer to 0, counter to 0;
- o_wb_valid, o_wb_idx, o_wb_data to 0;
- o_mc_pending to 0, o_mc_ready to 1 the cycle after reset deasserts.
REQ-023 Reset mid-operation SHALL discard any buffered result, with no write emitted.

Configuration
REQ-024 With WB_ARB_FLUSH_KILL_MC_EN defined, i_flush SHALL clear the buffer, counter and state to EMPTY at the same edge, and no write from it SHALL be emitted.
REQ-025 Without WB_ARB_FLUSH_KILL_MC_EN, i_flush SHALL affect only the pipe request, and the buffer SHALL drain normally.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- MC idx 3 data 0xAA while pipe idle -> the next cycle grants the buffer; o_wb_valid=1 idx 3 data 0xAA; o_mc_ready back to 1.
- MC idx 7 buffered, pipe valid continuously with idx 1..n, STARVE_LIMIT=4 -> four pipe writes, then one cycle o_pipe_stall=1, then the idx 7 write, then pipe resumes.
- Pipe idx 0 data 0x55 -> o_wb_valid=0, idx/data 0.
- i_flush with pipe valid idx 5 and buffer idx 9 -> no idx 5 write. Macro off: idx 9 written the next cycle. Macro on: no write, o_mc_pending=0.
- i_rst asserted while HELD -> all outputs 0; after release o_mc_ready=1 and no stale write.
- i_mc_valid held high with the buffer full -> exactly one acceptance per drain; no duplicate writes.

Source files
------------

// File: rtl/int_wb_arbiter.sv
// Regfile write-back arbiter: in-order commit pipe vs one-entry multi-cycle result buffer with starvation forcing.
// Optional WB_ARB_FLUSH_KILL_MC_EN: i_flush also discards the buffered MC result.
module int_wb_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned IDX_W        = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pipe_valid,
  input  logic [IDX_W-1:0]  i_pipe_idx,
  input  logic [DATA_W-1:0] i_pipe_data,
  output logic              o_pipe_stall,
  input  logic              i_mc_valid,
  input  logic [IDX_W-1:0]  i_mc_idx,
  input  logic [DATA_W-1:0] i_mc_data,
  output logic              o_mc_ready,
  input  logic              i_flush,
  output logic              o_wb_valid,
  output logic [IDX_W-1:0]  o_wb_idx,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_mc_pending
);

  typedef enum logic [1:0] {S_EMPTY, S_HELD, S_FORCE} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  buf_idx_q, buf_idx_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              ready_q, ready_d;
  logic              pend_q, pend_d;
  logic              wb_v_q, wb_v_d;
  logic [IDX_W-1:0]  wb_idx_q, wb_idx_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              pipe_eff, mc_acc, grant_pipe, grant_buf;

  assign o_pipe_stall = (state_q == S_FORCE);
  assign o_mc_ready   = ready_q;
  assign o_mc_pending = pend_q;
  assign o_wb_valid   = wb_v_q;
  assign o_wb_idx     = wb_idx_q;
  assign o_wb_data    = wb_data_q;

  assign pipe_eff = i_pipe_valid & ~i_flush & ~o_pipe_stall;
  assign mc_acc   = i_mc_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_idx_d  = buf_idx_q;
    buf_data_d = buf_data_q;
    grant_pipe = 1'b0;
    grant_buf  = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        cnt_d      = '0;
        grant_pipe = pipe_eff;
        if (mc_acc) begin
          state_d    = S_HELD;
          buf_idx_d  = i_mc_idx;
          buf_data_d = i_mc_data;
        end
      end
      S_HELD: begin
        if (pipe_eff) begin
          grant_pipe = 1'b1;
          cnt_d      = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
          if (cnt_d >= LIMIT) state_d = S_FORCE;
        end else begin
          grant_buf = 1'b1;
          cnt_d     = '0;
          state_d   = S_EMPTY;
        end
      end
      S_FORCE: begin
        grant_buf = 1'b1;
        cnt_d     = '0;
        state_d   = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
`ifdef WB_ARB_FLUSH_KILL_MC_EN
    // Flush wins over both a pending drain and a same-cycle MC capture.
    if (i_flush) begin
      grant_buf  = 1'b0;
      state_d    = S_EMPTY;
      cnt_d      = '0;
      buf_idx_d  = '0;
      buf_data_d = '0;
    end
`endif
    ready_d = (state_d == S_EMPTY);
    pend_d  = (state_d != S_EMPTY);

    // Index 0 is the hardwired zero register: the slot is used but nothing is written.
    wb_v_d    = 1'b0;
    wb_idx_d  = '0;
    wb_data_d = '0;
    if (grant_pipe && i_pipe_idx != '0) begin
      wb_v_d    = 1'b1;
      wb_idx_d  = i_pipe_idx;
      wb_data_d = i_pipe_data;
    end else if (grant_buf && buf_idx_q != '0) begin
      wb_v_d    = 1'b1;
      wb_idx_d  = buf_idx_q;
      wb_data_d = buf_data_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_EMPTY;
      cnt_q      <= '0;
      buf_idx_q  <= '0;
      buf_data_q <= '0;
      ready_q    <= 1'b0;
      pend_q     <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_idx_q  <= buf_idx_d;
      buf_data_q <= buf_data_d;
      ready_q    <= ready_d;
      pend_q     <= pend_d;
      wb_v_q     <= wb_v_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Directed bench for int_wb_arbiter; per-cycle expected write-back entries go through a scoreboard queue.
module tb_int_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_idx;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        mc_valid;
  logic [4:0]  mc_idx;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        mc_pending;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        v;
    logic [4:0]  idx;
    logic [31:0] data;
  } wb_t;
  wb_t sb[$];

  always #5 clk = ~clk;

  int_wb_arbiter #(.DATA_W(32), .IDX_W(5), .STARVE_LIMIT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pipe_valid(pipe_valid),
    .i_pipe_idx  (pipe_idx),
    .i_pipe_data (pipe_data),
    .o_pipe_stall(pipe_stall),
    .i_mc_valid  (mc_valid),
    .i_mc_idx    (mc_idx),
    .i_mc_data   (mc_data),
    .o_mc_ready  (mc_ready),
    .i_flush     (flush),
    .o_wb_valid  (wb_valid),
    .o_wb_idx    (wb_idx),
    .o_wb_data   (wb_data),
    .o_mc_pending(mc_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the write expected from this cycle's inputs, clock, then pop and compare.
  task automatic tick(input logic v, input logic [4:0] idx, input logic [31:0] data);
    wb_t e;
    sb.push_back({v, idx, data});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.v});
    chk("wb_idx",   {27'd0, wb_idx},   {27'd0, e.idx});
    chk("wb_data",  wb_data,           e.data);
  endtask

  initial begin
    rst = 1'b1; pipe_valid = 1'b0; pipe_idx = '0; pipe_data = '0;
    mc_valid = 1'b0; mc_idx = '0; mc_data = '0; flush = 1'b0;

    // Reset state
    tick(1'b0, 5'd0, 32'd0);
    tick(1'b0, 5'd0, 32'd0);
    chk("rst_ready",   {31'd0, mc_ready},   32'd0);
    chk("rst_pending", {31'd0, mc_pending}, 32'd0);
    chk("rst_stall",   {31'd0, pipe_stall}, 32'd0);
    rst = 1'b0;
    tick(1'b0, 5'd0, 32'd0);
    chk("post_rst_ready", {31'd0, mc_ready}, 32'd1);

    // MC result with idle pipe drains on the following cycle
    mc_valid = 1'b1; mc_idx = 5'd3; mc_data = 32'hAA;
    tick(1'b0, 5'd0, 32'd0);
    chk("s1_ready_busy", {31'd0, mc_ready},   32'd0);
    chk("s1_pending",    {31'd0, mc_pending}, 32'd1);
    mc_valid = 1'b0;
    tick(1'b1, 5'd3, 32'hAA);
    chk("s1_ready_back", {31'd0, mc_ready},   32'd1);
    chk("s1_pend_clr",   {31'd0, mc_pending}, 32'd0);
    tick(1'b0, 5'd0, 32'd0);

    // Starvation: four pipe wins, one stall cycle, then the buffered result
    mc_valid = 1'b1; mc_idx = 5'd7; mc_data = 32'h77;
    tick(1'b0, 5'd0, 32'd0);
    mc_valid = 1'b0;
    pipe_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      pipe_idx = 5'(i); pipe_data = 32'h100 + 32'(i);
      chk("s2_no_stall", {31'd0, pipe_stall}, 32'd0);
      tick(1'b1, 5'(i), 32'h100 + 32'(i));
    end
    chk("s2_stall", {31'd0, pipe_stall}, 32'd1);
    pipe_idx = 5'd5; pipe_data = 32'h105;
    tick(1'b1, 5'd7, 32'h77);
    chk("s2_stall_clr", {31'd0, pipe_stall}, 32'd0);
    chk("s2_ready",     {31'd0, mc_ready},   32'd1);
    tick(1'b1, 5'd5, 32'h105);
    pipe_valid = 1'b0;
    tick(1'b0, 5'd0, 32'd0);

    // Write to index 0 is suppressed
    pipe_valid = 1'b1; pipe_idx = 5'd0; pipe_data = 32'h55;
    tick(1'b0, 5'd0, 32'd0);
    pipe_valid = 1'b0;
    tick(1'b0, 5'd0, 32'd0);

    // Flush with pipe request and occupied buffer
    mc_valid = 1'b1; mc_idx = 5'd9; mc_data = 32'h99;
    tick(1'b0, 5'd0, 32'd0);
    mc_valid = 1'b0;
    pipe_valid = 1'b1; pipe_idx = 5'd5; pipe_data = 32'h5; flush = 1'b1;
`ifdef WB_ARB_FLUSH_KILL_MC_EN
    tick(1'b0, 5'd0, 32'd0);
`else
    tick(1'b1, 5'd9, 32'h99);
`endif
    chk("s4_pending", {31'd0, mc_pending}, 32'd0);
    chk("s4_ready",   {31'd0, mc_ready},   32'd1);
    pipe_valid = 1'b0; flush = 1'b0;
    tick(1'b0, 5'd0, 32'd0);

    // Reset while the buffer is held
    mc_valid = 1'b1; mc_idx = 5'd11; mc_data = 32'hBB;
    tick(1'b0, 5'd0, 32'd0);
    chk("s5_pending", {31'd0, mc_pending}, 32'd1);
    mc_valid = 1'b0; rst = 1'b1;
    tick(1'b0, 5'd0, 32'd0);
    chk("s5_rst_ready",   {31'd0, mc_ready},   32'd0);
    chk("s5_rst_pending", {31'd0, mc_pending}, 32'd0);
    rst = 1'b0;
    tick(1'b0, 5'd0, 32'd0);
    chk("s5_ready", {31'd0, mc_ready}, 32'd1);
    tick(1'b0, 5'd0, 32'd0);

    // MC valid held high: one acceptance per drain
    mc_valid = 1'b1; mc_idx = 5'd12;
    for (int i = 0; i < 3; i++) begin
      mc_data = 32'hC0 + 32'(i);
      tick(1'b0, 5'd0, 32'd0);
      chk("s6_ready_busy", {31'd0, mc_ready}, 32'd0);
      tick(1'b1, 5'd12, 32'hC0 + 32'(i));
    end
    mc_valid = 1'b0;
    tick(1'b0, 5'd0, 32'd0);
    tick(1'b0, 5'd0, 32'd0);
    chk("s6_pending", {31'd0, mc_pending}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
